clock_display: RTL

CLOCK_DISPLAY -- requirements
Module: clock_display

---
 rtl/clock_display.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/clock_display.sv
// ---------------------------------------------------------------------------
// clock_display
//   Drives a six-digit multiplexed common-anode 7-segment display showing
//   HH.MM.SS from binary hour/minute/second inputs.
//
//   A snapshot of {hr,min,sec} is converted to BCD by repeated subtraction
//   (IDLE -> CONV -> LOAD). All six display digits are written in one cycle,
//   so a half-converted time is never displayed. Input changes during a
//   conversion are picked up on the next IDLE cycle.
//
//   A scan counter cycles through the digits, showing each one for SCAN_DIV
//   clocks. seg/an/dp are registered from the previous cycle's digit index
//   and display digits.
//
// Ports
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   sec  in   [5:0] binary seconds
//   min  in   [5:0] binary minutes
//   hr   in   [4:0] binary hours
//   seg  out  [6:0] active-low segments, seg[0]=a .. seg[6]=g
//   an   out  [5:0] active-low digit enables, an[0]=sec units .. an[5]=hr tens
//   dp   out  active-low decimal point (separator after hr and min units)
// ---------------------------------------------------------------------------
module clock_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t      state_q, state_d;
  logic [16:0] cap_q, cap_d;
  logic [5:0]  ws_q, ws_d, wm_q, wm_d;
  logic [4:0]  wh_q, wh_d;
  logic [2:0]  ts_q, ts_d, tm_q, tm_d, th_q, th_d;
  // Display digits: {hr tens, hr units, min tens, min units, sec tens, sec units}
  logic [23:0] disp_q, disp_d;

  logic [SW-1:0] scan_q;
  logic [2:0]    digit_q;

  logic [6:0] seg_q, seg_d;
  logic [5:0] an_q, an_d;
  logic       dp_q, dp_d;
  logic [3:0] cur_val;

  logic [16:0] live;
  assign live = {hr, min, sec};

  // ---------------- conversion FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    ws_d    = ws_q;
    wm_d    = wm_q;
    wh_d    = wh_q;
    ts_d    = ts_q;
    tm_d    = tm_q;
    th_d    = th_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (live != cap_q) begin
          cap_d   = live;
          ws_d    = sec;
          wm_d    = min;
          wh_d    = hr;
          ts_d    = 3'd0;
          tm_d    = 3'd0;
          th_d    = 3'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (ws_q < 6'd10 && wm_q < 6'd10 && wh_q < 5'd10) begin
          state_d = LOAD;
        end else begin
          // Fields convert independently; the slowest one sets the latency.
          if (ws_q >= 6'd10) begin
            ws_d = ws_q - 6'd10;
            ts_d = ts_q + 3'd1;
          end
          if (wm_q >= 6'd10) begin
            wm_d = wm_q - 6'd10;
            tm_d = tm_q + 3'd1;
          end
          if (wh_q >= 5'd10) begin
            wh_d = wh_q - 5'd10;
            th_d = th_q + 3'd1;
          end
        end
      end
      LOAD: begin
        disp_d  = {1'b0, th_q, wh_q[3:0], 1'b0, tm_q, wm_q[3:0], 1'b0, ts_q, ws_q[3:0]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output encoding from previous-cycle state ----------------
  always_comb begin
    cur_val = disp_q[3:0];
    case (digit_q)
      3'd0:    cur_val = disp_q[3:0];
      3'd1:    cur_val = disp_q[7:4];
      3'd2:    cur_val = disp_q[11:8];
      3'd3:    cur_val = disp_q[15:12];
      3'd4:    cur_val = disp_q[19:16];
      3'd5:    cur_val = disp_q[23:20];
      default: cur_val = disp_q[3:0];
    endcase
  end

  always_comb begin
    seg_d = 7'h7F;
    case (cur_val)
      4'd0: seg_d = 7'b1000000;
      4'd1: seg_d = 7'b1111001;
      4'd2: seg_d = 7'b0100100;
      4'd3: seg_d = 7'b0110000;
      4'd4: seg_d = 7'b0011001;
      4'd5: seg_d = 7'b0010010;
      4'd6: seg_d = 7'b0000010;
      4'd7: seg_d = 7'b1111000;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0010000;
      default: seg_d = 7'h7F;
    endcase
    an_d = ~(6'd1 << digit_q);
    // Separator lit on hr/min units digits, blinking with the seconds parity.
    dp_d = ~(((digit_q == 3'd2) || (digit_q == 3'd4)) && !disp_q[0]);
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      ws_q    <= '0;
      wm_q    <= '0;
      wh_q    <= '0;
      ts_q    <= '0;
      tm_q    <= '0;
      th_q    <= '0;
      disp_q  <= '0;
      scan_q  <= '0;
      digit_q <= '0;
      seg_q   <= 7'h7F;
      an_q    <= 6'h3F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      ws_q    <= ws_d;
      wm_q    <= wm_d;
      wh_q    <= wh_d;
      ts_q    <= ts_d;
      tm_q    <= tm_d;
      th_q    <= th_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_q  <= '0;
        digit_q <= (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
      end else begin
        scan_q  <= scan_q + 1'b1;
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
